// File: rtl/data_sram_responder_if.sv
// SRAM-style data port between the core (master) and the data responder (slave).
interface data_sram_responder_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              sram_en;
    logic [BE_W-1:0]   sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        output sram_en,
        output sram_wen,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en,
        input  sram_wen,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data-port responder: on-chip word RAM plus LED/timer/compare/interrupt-status
// register window, with registered read data and interrupt vector.
module data_sram_responder #(
    parameter int unsigned RAM_AW        = 12,
    parameter logic [15:0] MMIO_BASE     = 16'hBFAF,
    parameter int unsigned TIMER_INT_BIT = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    data_sram_responder_if.slave       bus,
    output logic [5:0]                 int_out,
    output logic [15:0]                led,
    output logic                       err
);
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam int unsigned INT_W     = 6;
    localparam int unsigned LED_W     = 16;

    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_TIMER  = 16'hE000;
    localparam logic [15:0] OFF_CMP    = 16'hE004;
    localparam logic [15:0] OFF_STATUS = 16'hE008;

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    logic [DATA_W-1:0] timer;
    logic [DATA_W-1:0] compare;
    logic              int_status;

    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       offset;
    logic              is_write;
    logic              is_mmio;
    logic              ram_wr;
    logic              sel_led;
    logic              sel_timer;
    logic              sel_cmp;
    logic              sel_status;
    logic              sel_unmapped;
    logic              timer_match;

    logic [DATA_W-1:0] ram_old;
    logic [DATA_W-1:0] ram_merged;
    logic [DATA_W-1:0] timer_next;
    logic [DATA_W-1:0] compare_next;
    logic [LED_W-1:0]  led_next;
    logic              int_status_next;
    logic [DATA_W-1:0] rdata_next;
    logic [INT_W-1:0]  int_out_next;
    logic              err_next;

    // Byte address bits below word granularity carry no meaning here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.sram_addr[1:0];

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // Address decode
    always_comb begin
        ram_idx      = bus.sram_addr[RAM_AW+1:2];
        offset       = {bus.sram_addr[15:2], 2'b00};
        is_write     = |bus.sram_wen;
        is_mmio      = bus.sram_en && (bus.sram_addr[31:16] == MMIO_BASE);
        ram_wr       = bus.sram_en && !is_mmio && is_write;
        sel_led      = is_mmio && (offset == OFF_LED);
        sel_timer    = is_mmio && (offset == OFF_TIMER);
        sel_cmp      = is_mmio && (offset == OFF_CMP);
        sel_status   = is_mmio && (offset == OFF_STATUS);
        sel_unmapped = is_mmio && !(sel_led || sel_timer || sel_cmp || sel_status);
    end

    // Next register values; status set by a match wins over a clearing write
    always_comb begin
        ram_old    = mem[ram_idx];
        ram_merged = byte_merge(ram_old, bus.sram_wdata, bus.sram_wen);

        timer_next = timer + 32'd1;
        if (sel_timer && is_write) timer_next = byte_merge(timer, bus.sram_wdata, bus.sram_wen);

        compare_next = compare;
        if (sel_cmp && is_write) compare_next = byte_merge(compare, bus.sram_wdata, bus.sram_wen);

        led_next = led;
        if (sel_led && is_write) begin
            if (bus.sram_wen[0]) led_next[7:0]  = bus.sram_wdata[7:0];
            if (bus.sram_wen[1]) led_next[15:8] = bus.sram_wdata[15:8];
        end

        timer_match     = (timer == compare) && (compare != '0);
        int_status_next = int_status;
        if (timer_match)                  int_status_next = 1'b1;
        else if (sel_status && is_write)  int_status_next = 1'b0;

        int_out_next                = '0;
        int_out_next[TIMER_INT_BIT] = int_status;

        err_next = sel_unmapped;
    end

    // Read-data selection: writes return the post-write value
    always_comb begin
        rdata_next = bus.sram_rdata;
        if (bus.sram_en) begin
            if (!is_mmio) begin
                rdata_next = is_write ? ram_merged : ram_old;
            end else if (sel_led) begin
                rdata_next = {16'h0000, led_next};
            end else if (sel_timer) begin
                rdata_next = is_write ? timer_next : timer;
            end else if (sel_cmp) begin
                rdata_next = compare_next;
            end else if (sel_status) begin
                rdata_next = {31'd0, is_write ? int_status_next : int_status};
            end else begin
                rdata_next = '0;
            end
        end
    end

    // RAM array; requests in the reset cycle are dropped
    always_ff @(posedge clk) begin
        if (!rst && ram_wr) mem[ram_idx] <= ram_merged;
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sram_rdata <= '0;
            timer          <= '0;
            compare        <= '0;
            int_status     <= 1'b0;
            led            <= '0;
            int_out        <= '0;
            err            <= 1'b0;
        end else begin
            bus.sram_rdata <= rdata_next;
            timer          <= timer_next;
            compare        <= compare_next;
            int_status     <= int_status_next;
            led            <= led_next;
            int_out        <= int_out_next;
            err            <= err_next;
        end
    end
endmodule
